// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: RV32I multicycle sequencer (clk, rst, im_*/dm_* handshakes, ALU flags in; datapath strobes, control encodings, sticky halted/illegal/timeout and instret out)
module multicycle_control_unit #(
  parameter int CNT_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic [31:0] im_data,
  input  logic im_valid,
  input  logic dm_ready,
  input  logic ALUzero,
  input  logic ALUneg,
  output logic im_req,
  output logic dm_req,
  output logic ir_load,
  output logic pc_write,
  output logic RegWrite,
  output logic ALUsrc,
  output logic [1:0] PCsrc,
  output logic [1:0] MemWrite,
  output logic [2:0] ALUctl,
  output logic [2:0] MemtoReg,
  output logic halted,
  output logic illegal,
  output logic timeout,
  output logic [CNT_W-1:0] instret
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP} state_t;
  state_t state, state_n;
  logic [31:0] ir, wait_cnt;
  logic [6:0] op, f7;
  logic [2:0] f3, arith_ctl, dec_ctl, dec_m2r;
  logic is_r, is_i, is_ld, is_st, is_br, is_lui, is_auipc, is_jal, is_jalr;
  logic is_ebreak, bad, taken, dec_src, wd, retire;
  assign op = ir[6:0];
  assign f3 = ir[14:12];
  assign f7 = ir[31:25];
  assign is_r = op == 7'b0110011;
  assign is_i = op == 7'b0010011;
  assign is_ld = op == 7'b0000011;
  assign is_st = op == 7'b0100011;
  assign is_br = op == 7'b1100011;
  assign is_lui = op == 7'b0110111;
  assign is_auipc = op == 7'b0010111;
  assign is_jal = op == 7'b1101111;
  assign is_jalr = op == 7'b1100111;
  assign is_ebreak = ir == 32'h00100073;
  assign bad = !(is_r || is_i || is_ld || is_st || is_br || is_lui || is_auipc || is_jal || is_jalr) ||
               ((is_ld || is_st) && (f3[2] || f3 == 3'b011)) ||
               (is_br && f3[1]) ||
               ((is_r || is_i) && f3 == 3'b011) ||
               (is_r && ((f7 != 7'b0000000 && f7 != 7'b0100000) ||
                         (f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101)));
  assign arith_ctl = f3 == 3'b000 ? (is_r && f7[5] ? 3'd6 : 3'd0) :
                     f3 == 3'b001 ? 3'd3 :
                     f3 == 3'b010 ? 3'd6 :
                     f3 == 3'b100 ? 3'd7 :
                     f3 == 3'b101 ? (ir[30] ? 3'd4 : 3'd5) :
                     f3 == 3'b110 ? 3'd2 : 3'd1;
  assign dec_ctl = (is_r || is_i) ? arith_ctl : is_br ? 3'd6 : 3'd0;
  assign dec_src = !(is_r || is_br);
  assign dec_m2r = (is_jal || is_jalr) ? 3'd1 :
                   is_lui ? 3'd2 :
                   is_auipc ? 3'd3 :
                   is_ld ? {1'b1, f3[1:0]} :
                   ((is_r || is_i) && f3 == 3'b010) ? 3'd7 : 3'd0;
  assign taken = f3 == 3'b000 ? ALUzero :
                 f3 == 3'b001 ? !ALUzero :
                 f3 == 3'b100 ? ALUneg : !ALUneg;
  assign wd = TIMEOUT != 0 && wait_cnt == 32'(TIMEOUT);
  always_comb begin
    state_n = state;
    im_req = 1'b0;
    dm_req = 1'b0;
    ir_load = 1'b0;
    pc_write = 1'b0;
    RegWrite = 1'b0;
    ALUsrc = 1'b0;
    PCsrc = 2'd0;
    MemWrite = 2'd0;
    ALUctl = 3'd0;
    MemtoReg = 3'd0;
    retire = 1'b0;
    if (!rst) begin
      if (state == EXEC || state == MEM || state == WB) {ALUsrc, ALUctl, MemtoReg} = {dec_src, dec_ctl, dec_m2r};
      case (state)
        FETCH: begin
          im_req = 1'b1;
          ir_load = im_valid;
          state_n = im_valid ? DECODE : wd ? TRAP : FETCH;
        end
        DECODE: state_n = is_ebreak ? HALT : bad ? TRAP : EXEC;
        EXEC: begin
          pc_write = is_br;
          PCsrc = {1'b0, is_br && taken};
          retire = is_br;
          state_n = is_br ? FETCH : (is_ld || is_st) ? MEM : WB;
        end
        MEM: begin
          dm_req = 1'b1;
          MemWrite = is_st ? f3[1:0] + 2'd1 : 2'd0;
          pc_write = dm_ready && is_st;
          retire = dm_ready && is_st;
          state_n = dm_ready ? (is_st ? FETCH : WB) : wd ? TRAP : MEM;
        end
        WB: begin
          RegWrite = ir[11:7] != 5'd0;
          pc_write = 1'b1;
          PCsrc = is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
          retire = 1'b1;
          state_n = FETCH;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      ir <= '0;
      wait_cnt <= '0;
      instret <= '0;
      halted <= 1'b0;
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      if (ir_load) ir <= im_data;
      wait_cnt <= state_n != state ? '0 : wait_cnt + 32'((state == FETCH && !im_valid) || (state == MEM && !dm_ready));
      if (retire) instret <= instret + CNT_W'(1);
      halted <= halted || state_n == HALT;
      illegal <= illegal || (state == DECODE && state_n == TRAP);
      timeout <= timeout || ((state == FETCH || state == MEM) && state_n == TRAP);
    end
  end
endmodule
